lf_mode_sequencer: RTL and testbench



---
 rtl/lf_mode_sequencer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_lf_mode_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lf_mode_sequencer.sv
// lf_mode_sequencer
// Serialises LF reconfiguration requests from the SPI command decoder into the
// pck0 domain. A configuration change is bracketed by a field-off guard period
// and a settle period so the coil is never driven while the major-mode muxes
// are switching. Divisor updates are held until the divider wraps so the
// divided clock never sees a short or long pulse.
//
// Optional build macro: LF_ED_DEFAULT_THRESHOLD_EN
//   When defined, applying conf_word 8'h01 (LF edge detect, field on) also
//   loads user_byte1 with the default edge-detect threshold 8'd127, unless an
//   explicit SET_USER_BYTE1 arrives in the same cycle.
//   When undefined, applying a configuration never touches user_byte1.

module lf_mode_sequencer #(
    parameter int GUARD_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 32,
    parameter int CNT_W         = 8
) (
    input  logic        pck0,
    input  logic        rst,
    input  logic        cmd_strobe,
    input  logic [15:0] cmd_word,
    input  logic        div_wrap,
    output logic [7:0]  conf_word,
    output logic [2:0]  major_mode,
    output logic [7:0]  divisor,
    output logic [7:0]  user_byte1,
    output logic        field_en,
    output logic        busy,
    output logic        cmd_overflow
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_QUIESCE = 2'd1;
    localparam logic [1:0] ST_APPLY   = 2'd2;
    localparam logic [1:0] ST_SETTLE  = 2'd3;

    // Command opcodes
    localparam logic [3:0] OP_SET_CONF       = 4'b0001;
    localparam logic [3:0] OP_SET_DIVISOR    = 4'b0010;
    localparam logic [3:0] OP_SET_USER_BYTE1 = 4'b0011;

    // Reset values
    localparam logic [7:0] CONF_RESET    = 8'hE0;
    localparam logic [7:0] DIVISOR_RESET = 8'd95;
    localparam logic [7:0] UB1_RESET     = 8'd0;
    localparam logic [2:0] MODE_OFF      = 3'b111;

`ifdef LF_ED_DEFAULT_THRESHOLD_EN
    localparam logic [7:0] CONF_LF_ED      = 8'h01;
    localparam logic [7:0] ED_DEFAULT_THR  = 8'd127;
`endif

    // Guard/settle counter constants; both loads fit in CNT_W by construction
    localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Registered state
    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       next_conf_r;
    logic [7:0]       conf_r;
    logic             conf_pend_valid_r;
    logic [7:0]       conf_pend_r;
    logic             div_pend_valid_r;
    logic [7:0]       div_pend_r;
    logic [7:0]       divisor_r;
    logic [7:0]       user_byte1_r;
    logic             field_en_r;
    logic             busy_r;
    logic             cmd_overflow_r;

    // Next-state values
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [7:0]       next_conf_nxt_s;
    logic [7:0]       conf_nxt_s;
    logic             conf_pend_valid_nxt_s;
    logic [7:0]       conf_pend_nxt_s;
    logic             overflow_nxt_s;
    logic             div_pend_valid_nxt_s;
    logic [7:0]       div_pend_nxt_s;
    logic [7:0]       divisor_nxt_s;
    logic [7:0]       user_byte1_nxt_s;
    logic             field_en_nxt_s;
    logic             busy_nxt_s;

    // Command decode
    logic [3:0] opcode_s;
    logic [7:0] payload_s;
    logic       is_set_conf_s;
    logic       is_set_div_s;
    logic       is_set_ub1_s;
    logic       unused_cmd_bits_s;

    assign opcode_s          = cmd_word[15:12];
    assign payload_s         = cmd_word[7:0];
    assign unused_cmd_bits_s = ^cmd_word[11:8];
    assign is_set_conf_s     = cmd_strobe && (opcode_s == OP_SET_CONF);
    assign is_set_div_s      = cmd_strobe && (opcode_s == OP_SET_DIVISOR);
    assign is_set_ub1_s      = cmd_strobe && (opcode_s == OP_SET_USER_BYTE1);

    // Reconfiguration FSM, conf pending buffer and overflow detection
    always_comb begin
        state_nxt_s           = state_r;
        cnt_nxt_s             = cnt_r;
        next_conf_nxt_s       = next_conf_r;
        conf_nxt_s            = conf_r;
        conf_pend_valid_nxt_s = conf_pend_valid_r;
        conf_pend_nxt_s       = conf_pend_r;
        overflow_nxt_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (conf_pend_valid_r) begin
                    // Drain the buffered request; a strobe arriving now
                    // takes the slot that is being freed.
                    next_conf_nxt_s       = conf_pend_r;
                    state_nxt_s           = ST_QUIESCE;
                    cnt_nxt_s             = GUARD_LOAD;
                    conf_pend_valid_nxt_s = is_set_conf_s;
                    if (is_set_conf_s) begin
                        conf_pend_nxt_s = payload_s;
                    end else begin
                        conf_pend_nxt_s = conf_pend_r;
                    end
                end else if (is_set_conf_s && (payload_s != conf_r)) begin
                    next_conf_nxt_s = payload_s;
                    state_nxt_s     = ST_QUIESCE;
                    cnt_nxt_s       = GUARD_LOAD;
                end else begin
                    // Nothing to do, or a SET_CONF that matches the
                    // configuration already applied.
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_QUIESCE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_APPLY;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_APPLY: begin
                conf_nxt_s  = next_conf_r;
                state_nxt_s = ST_SETTLE;
                cnt_nxt_s   = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase

        // While a sequence is in flight, SET_CONF goes to the one-entry
        // buffer; if it is occupied the oldest request is kept.
        if ((state_r != ST_IDLE) && is_set_conf_s) begin
            if (conf_pend_valid_r) begin
                overflow_nxt_s = 1'b1;
            end else begin
                conf_pend_valid_nxt_s = 1'b1;
                conf_pend_nxt_s       = payload_s;
            end
        end else begin
            overflow_nxt_s = 1'b0;
        end
    end

    // Divisor pending register: apply only on a wrap after the strobe cycle
    always_comb begin
        div_pend_valid_nxt_s = div_pend_valid_r;
        div_pend_nxt_s       = div_pend_r;
        divisor_nxt_s        = divisor_r;
        if (is_set_div_s) begin
            // A wrap coinciding with the strobe is not used.
            div_pend_valid_nxt_s = 1'b1;
            div_pend_nxt_s       = payload_s;
        end else if (div_wrap && div_pend_valid_r) begin
            divisor_nxt_s        = div_pend_r;
            div_pend_valid_nxt_s = 1'b0;
        end else begin
            div_pend_valid_nxt_s = div_pend_valid_r;
        end
    end

    // User byte: explicit command always wins over any default threshold
    always_comb begin
        user_byte1_nxt_s = user_byte1_r;
`ifdef LF_ED_DEFAULT_THRESHOLD_EN
        if ((state_r == ST_APPLY) && (next_conf_r == CONF_LF_ED)) begin
            user_byte1_nxt_s = ED_DEFAULT_THR;
        end else begin
            user_byte1_nxt_s = user_byte1_r;
        end
`endif
        if (is_set_ub1_s) begin
            user_byte1_nxt_s = payload_s;
        end else begin
            user_byte1_nxt_s = user_byte1_nxt_s;
        end
    end

    // Status outputs computed from next state so they line up with the state
    always_comb begin
        field_en_nxt_s = (state_nxt_s == ST_IDLE) && (conf_nxt_s[7:5] != MODE_OFF);
        busy_nxt_s     = (state_nxt_s != ST_IDLE) || div_pend_valid_nxt_s;
    end

    // FSM and conf buffer registers
    always_ff @(posedge pck0) begin
        if (rst) begin
            state_r           <= ST_IDLE;
            cnt_r             <= CNT_ZERO;
            next_conf_r       <= CONF_RESET;
            conf_r            <= CONF_RESET;
            conf_pend_valid_r <= 1'b0;
            conf_pend_r       <= 8'h00;
            cmd_overflow_r    <= 1'b0;
        end else begin
            state_r           <= state_nxt_s;
            cnt_r             <= cnt_nxt_s;
            next_conf_r       <= next_conf_nxt_s;
            conf_r            <= conf_nxt_s;
            conf_pend_valid_r <= conf_pend_valid_nxt_s;
            conf_pend_r       <= conf_pend_nxt_s;
            cmd_overflow_r    <= overflow_nxt_s;
        end
    end

    // Divisor and user byte registers
    always_ff @(posedge pck0) begin
        if (rst) begin
            div_pend_valid_r <= 1'b0;
            div_pend_r       <= 8'h00;
            divisor_r        <= DIVISOR_RESET;
            user_byte1_r     <= UB1_RESET;
        end else begin
            div_pend_valid_r <= div_pend_valid_nxt_s;
            div_pend_r       <= div_pend_nxt_s;
            divisor_r        <= divisor_nxt_s;
            user_byte1_r     <= user_byte1_nxt_s;
        end
    end

    // Field gate and busy flag registers
    always_ff @(posedge pck0) begin
        if (rst) begin
            field_en_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            field_en_r <= field_en_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign conf_word    = conf_r;
    assign major_mode   = conf_r[7:5];
    assign divisor      = divisor_r;
    assign user_byte1   = user_byte1_r;
    assign field_en     = field_en_r;
    assign busy         = busy_r;
    assign cmd_overflow = cmd_overflow_r;

endmodule

// File: tb/tb_lf_mode_sequencer.sv
// Directed self-checking bench for lf_mode_sequencer with default parameters.
module tb_lf_mode_sequencer;

    localparam int G = 16;
    localparam int S = 32;

`ifdef LF_ED_DEFAULT_THRESHOLD_EN
    localparam logic [7:0] UB_AFTER_ED = 8'd127;
`else
    localparam logic [7:0] UB_AFTER_ED = 8'd0;
`endif

    logic        pck0;
    logic        rst;
    logic        cmd_strobe;
    logic [15:0] cmd_word;
    logic        div_wrap;
    logic [7:0]  conf_word;
    logic [2:0]  major_mode;
    logic [7:0]  divisor;
    logic [7:0]  user_byte1;
    logic        field_en;
    logic        busy;
    logic        cmd_overflow;

    int n_checks;
    int n_fail;

    lf_mode_sequencer #(
        .GUARD_CYCLES (G),
        .SETTLE_CYCLES(S),
        .CNT_W        (8)
    ) dut (
        .pck0        (pck0),
        .rst         (rst),
        .cmd_strobe  (cmd_strobe),
        .cmd_word    (cmd_word),
        .div_wrap    (div_wrap),
        .conf_word   (conf_word),
        .major_mode  (major_mode),
        .divisor     (divisor),
        .user_byte1  (user_byte1),
        .field_en    (field_en),
        .busy        (busy),
        .cmd_overflow(cmd_overflow)
    );

    initial pck0 = 1'b0;
    always #5 pck0 = ~pck0;

    task automatic tick();
        @(posedge pck0);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (conf_word !== 8'hE0) begin n_fail++; $display("FAIL reset conf_word got %h exp e0", conf_word); end
        n_checks++;
        if (major_mode !== 3'b111) begin n_fail++; $display("FAIL reset major_mode got %b exp 111", major_mode); end
        n_checks++;
        if (divisor !== 8'd95) begin n_fail++; $display("FAIL reset divisor got %0d exp 95", divisor); end
        n_checks++;
        if (user_byte1 !== 8'd0) begin n_fail++; $display("FAIL reset user_byte1 got %0d exp 0", user_byte1); end
        n_checks++;
        if ({field_en, busy, cmd_overflow} !== 3'b000) begin
            n_fail++; $display("FAIL reset flags got %b%b%b exp 000", field_en, busy, cmd_overflow);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    // SET_CONF 0x01 from OFF: guard, apply, settle timing
    task automatic test_conf_latency();
        logic       exp_b;
        logic [7:0] exp_v;
        cmd_word = 16'h1001; cmd_strobe = 1'b1;
        tick();
        cmd_strobe = 1'b0; cmd_word = 16'h0000;
        for (int k = 1; k <= G + S + 2; k++) begin
            exp_b = (k <= G + S + 1);
            n_checks++;
            if (busy !== exp_b) begin n_fail++; $display("FAIL conf_latency busy k=%0d got %b exp %b", k, busy, exp_b); end
            exp_b = (k >= G + S + 2);
            n_checks++;
            if (field_en !== exp_b) begin n_fail++; $display("FAIL conf_latency field_en k=%0d got %b exp %b", k, field_en, exp_b); end
            exp_v = (k >= G + 2) ? 8'h01 : 8'hE0;
            n_checks++;
            if (conf_word !== exp_v) begin n_fail++; $display("FAIL conf_latency conf_word k=%0d got %h exp %h", k, conf_word, exp_v); end
            exp_v = (k >= G + 2) ? UB_AFTER_ED : 8'd0;
            n_checks++;
            if (user_byte1 !== exp_v) begin n_fail++; $display("FAIL conf_latency user_byte1 k=%0d got %h exp %h", k, user_byte1, exp_v); end
            tick();
        end
    endtask

    // SET_DIVISOR coinciding with a wrap, then overwritten before the next wrap
    task automatic test_divisor();
        logic [7:0] exp_v;
        logic       exp_b;
        for (int c = 0; c <= 200; c++) begin
            div_wrap = ((c % 96) == 0);
            if (c == 0) begin
                cmd_strobe = 1'b1; cmd_word = 16'h2011;
            end else if (c == 40) begin
                cmd_strobe = 1'b1; cmd_word = 16'h2059;
            end else begin
                cmd_strobe = 1'b0; cmd_word = 16'h0000;
            end
            tick();
            exp_v = (c >= 96) ? 8'h59 : 8'd95;
            n_checks++;
            if (divisor !== exp_v) begin n_fail++; $display("FAIL divisor c=%0d got %h exp %h", c, divisor, exp_v); end
            exp_b = (c < 96);
            n_checks++;
            if (busy !== exp_b) begin n_fail++; $display("FAIL divisor busy c=%0d got %b exp %b", c, busy, exp_b); end
        end
        div_wrap = 1'b0; cmd_strobe = 1'b0; cmd_word = 16'h0000;
        tick();
    endtask

    // SET_USER_BYTE1 during QUIESCE of a 0x01 -> 0x20 change
    task automatic test_user_byte_in_quiesce();
        logic [7:0] exp_v;
        logic       exp_b;
        cmd_word = 16'h1020; cmd_strobe = 1'b1;
        tick();
        cmd_strobe = 1'b0; cmd_word = 16'h0000;
        for (int k = 1; k <= G + S + 2; k++) begin
            exp_v = (k >= 4) ? 8'h40 : UB_AFTER_ED;
            n_checks++;
            if (user_byte1 !== exp_v) begin n_fail++; $display("FAIL ub_quiesce user_byte1 k=%0d got %h exp %h", k, user_byte1, exp_v); end
            exp_v = (k >= G + 2) ? 8'h20 : 8'h01;
            n_checks++;
            if (conf_word !== exp_v) begin n_fail++; $display("FAIL ub_quiesce conf_word k=%0d got %h exp %h", k, conf_word, exp_v); end
            exp_b = (k >= G + S + 2);
            n_checks++;
            if (field_en !== exp_b) begin n_fail++; $display("FAIL ub_quiesce field_en k=%0d got %b exp %b", k, field_en, exp_b); end
            if (k == 3) begin
                cmd_strobe = 1'b1; cmd_word = 16'h3040;
            end else begin
                cmd_strobe = 1'b0; cmd_word = 16'h0000;
            end
            tick();
        end
    endtask

    // Three SET_CONF back to back: run, buffer, drop
    task automatic test_back_to_back();
        logic [7:0] exp_v;
        logic       exp_b;
        cmd_word = 16'h1000; cmd_strobe = 1'b1;
        tick();
        for (int k = 1; k <= 2 * G + 2 * S + 4; k++) begin
            exp_b = (k == 3);
            n_checks++;
            if (cmd_overflow !== exp_b) begin n_fail++; $display("FAIL b2b cmd_overflow k=%0d got %b exp %b", k, cmd_overflow, exp_b); end
            exp_v = (k < G + 2) ? 8'h20 : ((k < 2 * G + S + 4) ? 8'h00 : 8'h20);
            n_checks++;
            if (conf_word !== exp_v) begin n_fail++; $display("FAIL b2b conf_word k=%0d got %h exp %h", k, conf_word, exp_v); end
            if (k < G + S + 2) begin
                n_checks++;
                if (field_en !== 1'b0) begin n_fail++; $display("FAIL b2b field_en k=%0d got %b exp 0", k, field_en); end
            end
            if (k == 1) begin
                cmd_strobe = 1'b1; cmd_word = 16'h1020;
            end else if (k == 2) begin
                cmd_strobe = 1'b1; cmd_word = 16'h1040;
            end else begin
                cmd_strobe = 1'b0; cmd_word = 16'h0000;
            end
            tick();
        end
        // Now one cycle after the second sequence returned to IDLE
        n_checks++;
        if (field_en !== 1'b1) begin n_fail++; $display("FAIL b2b final field_en got %b exp 1", field_en); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b final busy got %b exp 0", busy); end
        n_checks++;
        if (conf_word !== 8'h20) begin n_fail++; $display("FAIL b2b final conf_word got %h exp 20", conf_word); end
    endtask

    // rst during SETTLE with a buffered request, then a normal sequence
    task automatic test_reset_in_settle();
        logic [7:0] exp_v;
        logic       exp_b;
        cmd_word = 16'h1001; cmd_strobe = 1'b1;
        tick();
        for (int k = 1; k <= G + 5; k++) begin
            if (k == 2) begin
                cmd_strobe = 1'b1; cmd_word = 16'h1040;
            end else begin
                cmd_strobe = 1'b0; cmd_word = 16'h0000;
            end
            if (k == G + 5) rst = 1'b1;
            tick();
        end
        rst = 1'b0; cmd_strobe = 1'b0; cmd_word = 16'h0000;
        n_checks++;
        if (conf_word !== 8'hE0) begin n_fail++; $display("FAIL rst_settle conf_word got %h exp e0", conf_word); end
        n_checks++;
        if (field_en !== 1'b0) begin n_fail++; $display("FAIL rst_settle field_en got %b exp 0", field_en); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_settle busy got %b exp 0", busy); end
        n_checks++;
        if (user_byte1 !== 8'd0) begin n_fail++; $display("FAIL rst_settle user_byte1 got %h exp 00", user_byte1); end
        n_checks++;
        if (divisor !== 8'd95) begin n_fail++; $display("FAIL rst_settle divisor got %0d exp 95", divisor); end
        // A discarded buffer must never start a sequence on its own
        for (int i = 0; i < G + S + 8; i++) begin
            tick();
            n_checks++;
            if (busy !== 1'b0 || conf_word !== 8'hE0) begin
                n_fail++; $display("FAIL rst_settle idle i=%0d busy %b conf %h exp busy 0 conf e0", i, busy, conf_word);
            end
        end
        cmd_word = 16'h1060; cmd_strobe = 1'b1;
        tick();
        cmd_strobe = 1'b0; cmd_word = 16'h0000;
        for (int k = 1; k <= G + S + 2; k++) begin
            exp_v = (k >= G + 2) ? 8'h60 : 8'hE0;
            n_checks++;
            if (conf_word !== exp_v) begin n_fail++; $display("FAIL rst_settle resume conf k=%0d got %h exp %h", k, conf_word, exp_v); end
            exp_b = (k >= G + S + 2);
            n_checks++;
            if (field_en !== exp_b) begin n_fail++; $display("FAIL rst_settle resume field_en k=%0d got %b exp %b", k, field_en, exp_b); end
            tick();
        end
    endtask

    // Same-value SET_CONF is a no-op; change to OFF keeps field off
    task automatic test_noop_and_off();
        cmd_word = 16'h1000; cmd_strobe = 1'b1;
        tick();
        cmd_strobe = 1'b0; cmd_word = 16'h0000;
        for (int i = 0; i < G + S + 1; i++) tick();
        n_checks++;
        if (conf_word !== 8'h00 || field_en !== 1'b1) begin
            n_fail++; $display("FAIL noop setup conf %h field_en %b exp 00 1", conf_word, field_en);
        end
        cmd_word = 16'h1000; cmd_strobe = 1'b1;
        tick();
        cmd_strobe = 1'b0; cmd_word = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (field_en !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL noop i=%0d field_en %b busy %b exp 1 0", i, field_en, busy);
            end
            tick();
        end
        cmd_word = 16'h10E0; cmd_strobe = 1'b1;
        tick();
        cmd_strobe = 1'b0; cmd_word = 16'h0000;
        n_checks++;
        if (field_en !== 1'b0) begin n_fail++; $display("FAIL off field_en drop got %b exp 0", field_en); end
        for (int i = 1; i < G + 2; i++) tick();
        n_checks++;
        if (conf_word !== 8'hE0) begin n_fail++; $display("FAIL off conf_word got %h exp e0", conf_word); end
        for (int i = G + 2; i < G + S + 2; i++) tick();
        n_checks++;
        if (field_en !== 1'b0) begin n_fail++; $display("FAIL off field_en after settle got %b exp 0", field_en); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL off busy after settle got %b exp 0", busy); end
    endtask

    // Unknown opcodes change nothing
    task automatic test_ignored_opcodes();
        cmd_word = 16'h4055; cmd_strobe = 1'b1;
        tick();
        cmd_word = 16'h0001;
        tick();
        cmd_strobe = 1'b0; cmd_word = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (busy !== 1'b0 || cmd_overflow !== 1'b0 || conf_word !== 8'hE0 ||
                user_byte1 !== 8'd0 || divisor !== 8'd95) begin
                n_fail++;
                $display("FAIL ignored i=%0d busy %b ovf %b conf %h ub %h div %0d exp 0 0 e0 00 95",
                         i, busy, cmd_overflow, conf_word, user_byte1, divisor);
            end
            tick();
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        cmd_strobe = 1'b0;
        cmd_word   = 16'h0000;
        div_wrap   = 1'b0;
        test_reset();
        test_conf_latency();
        test_divisor();
        test_user_byte_in_quiesce();
        test_back_to_back();
        test_reset_in_settle();
        test_noop_and_off();
        test_ignored_opcodes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
